// File: rtl/axicb_slv_rd_cpl_switch.sv
// Read completion switch: muxes the granted slave's R channel to the master or
// generates a local DECERR burst for misrouted reads. Optional macro: AXICB_RCH_PIPE_EN.
module axicb_slv_rd_cpl_switch #(
  parameter int AXI_ID_W   = 8,
  parameter int AXI_DATA_W = 32,
  parameter int SLV_NB     = 4
) (
  input  logic                         aclk,
  input  logic                         srst,
  output logic                         c_en,
  input  logic [SLV_NB-1:0]            c_grant,
  input  logic                         c_mr,
  input  logic [7:0]                   c_len,
  input  logic [AXI_ID_W-1:0]          c_id,
  output logic                         c_end,
  input  logic [SLV_NB-1:0]            s_rvalid,
  output logic [SLV_NB-1:0]            s_rready,
  input  logic [AXI_ID_W*SLV_NB-1:0]   s_rid,
  input  logic [2*SLV_NB-1:0]          s_rresp,
  input  logic [AXI_DATA_W*SLV_NB-1:0] s_rdata,
  input  logic [SLV_NB-1:0]            s_rlast,
  output logic                         m_rvalid,
  input  logic                         m_rready,
  output logic [AXI_ID_W-1:0]          m_rid,
  output logic [1:0]                   m_rresp,
  output logic [AXI_DATA_W-1:0]        m_rdata,
  output logic                         m_rlast
);

  localparam int IDX_W = (SLV_NB > 1) ? $clog2(SLV_NB) : 1;
  localparam int PL_W  = AXI_ID_W + 2 + AXI_DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    MR   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  state_t                 w_state_eff;
  logic [SLV_NB-1:0]      r_grant;
  logic [IDX_W-1:0]       r_idx;
  logic [7:0]             r_len;
  logic [7:0]             r_cnt;
  logic [AXI_ID_W-1:0]    r_id;

  logic [SLV_NB-1:0]      w_grant_lo;
  logic [IDX_W-1:0]       w_grant_idx;
  logic                   w_accept;
  logic                   w_beat;
  logic                   w_last_beat;
  logic                   w_src_valid;
  logic [AXI_ID_W-1:0]    w_src_id;
  logic [1:0]             w_src_resp;
  logic [AXI_DATA_W-1:0]  w_src_data;
  logic                   w_src_last;
  logic [SLV_NB-1:0]      w_slv_rdy;

  // Only the lowest set bit of a multi-hot grant is honoured.
  assign w_grant_lo = c_grant & (~c_grant + SLV_NB'(1));

  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < SLV_NB; i++) begin
      w_grant_idx = w_grant_idx | ({IDX_W{w_grant_lo[i]}} & IDX_W'(i));
    end
  end

  // srst forces the datapath idle in the same cycle so an abort is immediate.
  assign w_state_eff = srst ? IDLE : r_state;

  always_comb begin
    w_src_valid = 1'b0;
    w_src_id    = '0;
    w_src_resp  = 2'b00;
    w_src_data  = '0;
    w_src_last  = 1'b0;
    w_slv_rdy   = '0;
    case (w_state_eff)
      PASS: begin
        w_src_valid = |(s_rvalid & r_grant);
        w_src_id    = s_rid[r_idx*AXI_ID_W +: AXI_ID_W];
        w_src_resp  = s_rresp[r_idx*2 +: 2];
        w_src_data  = s_rdata[r_idx*AXI_DATA_W +: AXI_DATA_W];
        w_src_last  = s_rlast[r_idx];
        w_slv_rdy   = r_grant & {SLV_NB{w_accept}};
      end
      MR: begin
        w_src_valid = 1'b1;
        w_src_id    = r_id;
        w_src_resp  = 2'b11;
        w_src_last  = (r_cnt == r_len);
      end
      default: begin
        w_src_valid = 1'b0;
      end
    endcase
  end

  assign w_beat      = w_src_valid & w_accept;
  assign w_last_beat = w_beat & w_src_last;
  assign c_end       = w_last_beat;
  assign c_en        = w_last_beat;
  assign s_rready    = w_slv_rdy;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (|c_grant) begin
          w_state_nxt = c_mr ? MR : PASS;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      PASS, MR: begin
        if (w_last_beat) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_len   <= 8'd0;
      r_id    <= '0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && |c_grant) begin
        r_grant <= w_grant_lo;
        r_idx   <= w_grant_idx;
        r_len   <= c_len;
        r_id    <= c_id;
        r_cnt   <= 8'd0;
      end else if (w_beat && r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

`ifdef AXICB_RCH_PIPE_EN
  logic [1:0]      r_bcnt;
  logic [PL_W-1:0] r_bd0;
  logic [PL_W-1:0] r_bd1;
  logic [PL_W-1:0] w_pl;
  logic            w_pop;

  // Two entries let the source keep streaming while the head waits on m_rready.
  assign w_pl     = {w_src_id, w_src_resp, w_src_data, w_src_last};
  assign w_accept = (r_bcnt != 2'd2);
  assign w_pop    = (r_bcnt != 2'd0) & m_rready;
  assign m_rvalid = (r_bcnt != 2'd0);
  assign {m_rid, m_rresp, m_rdata, m_rlast} = (r_bcnt != 2'd0) ? r_bd0 : {PL_W{1'b0}};

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_bcnt <= 2'd0;
      r_bd0  <= '0;
      r_bd1  <= '0;
    end else begin
      case ({w_beat, w_pop})
        2'b10: begin
          if (r_bcnt == 2'd0) begin
            r_bd0 <= w_pl;
          end else begin
            r_bd1 <= w_pl;
          end
          r_bcnt <= r_bcnt + 2'd1;
        end
        2'b01: begin
          r_bd0  <= r_bd1;
          r_bcnt <= r_bcnt - 2'd1;
        end
        2'b11: begin
          if (r_bcnt == 2'd1) begin
            r_bd0 <= w_pl;
          end else begin
            r_bd0 <= r_bd1;
            r_bd1 <= w_pl;
          end
        end
        default: begin
          r_bcnt <= r_bcnt;
        end
      endcase
    end
  end
`else
  assign w_accept = m_rready;
  assign m_rvalid = w_src_valid;
  assign m_rid    = w_src_id;
  assign m_rresp  = w_src_resp;
  assign m_rdata  = w_src_data;
  assign m_rlast  = w_src_last;
`endif

endmodule
